// File: rtl/const_enc_ctrl.sv
// Constellation-encoder sequencer: loads the bit-loading table into the encoder,
// then streams FIFO bytes one DMT symbol at a time and tracks symbol completion.
module const_enc_ctrl #(
  parameter int NUM_BINS  = 256,
  parameter int ADDR_W    = 8,
  parameter int SYM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic [ADDR_W-1:0]    tbl_addr_o,
  input  logic [3:0]           tbl_data_i,
  output logic                 enc_we_conf_o,
  output logic [ADDR_W-1:0]    enc_addr_o,
  output logic [3:0]           enc_conf_data_o,
  input  logic                 enc_input_ready_i,
  output logic                 enc_we_data_o,
  output logic [7:0]           enc_data_o,
  input  logic                 fifo_empty_i,
  input  logic [7:0]           fifo_data_i,
  output logic                 fifo_rd_o,
  input  logic                 xy_ready_i,
  input  logic [ADDR_W-1:0]    bin_num_i,
  output logic                 busy_o,
  output logic                 cfg_done_o,
  output logic                 cfg_err_o,
  output logic                 sym_done_o,
  output logic [SYM_CNT_W-1:0] sym_cnt_o,
  output logic                 underrun_o,
  output logic [8:0]           bytes_per_sym_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CFG   = 2'd1;
  localparam logic [1:0] FEED  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  logic [1:0]        state;
  logic              rd_active;
  logic              stop_latched;
  logic [11:0]       total_bits;
  logic [ADDR_W-1:0] last_bin;
  logic [8:0]        bytes_left;
  logic [12:0]       total_sum;
  logic              byte_fire;
  logic              xy_hit;
  logic              stop_now;

  assign byte_fire     = (state == FEED) & enc_input_ready_i & ~fifo_empty_i;
  assign fifo_rd_o     = byte_fire;
  assign enc_we_data_o = byte_fire;
  assign enc_data_o    = fifo_data_i;
  assign busy_o        = (state != IDLE);

  // Table RAM has a registered read, so its data lines up with the delayed write strobe.
  assign enc_conf_data_o = enc_we_conf_o ? tbl_data_i : 4'd0;

  // Running total including the entry being written now, pre-biased for the ceil divide.
  assign total_sum = {1'b0, total_bits} + 13'(tbl_data_i) + 13'd7;
  assign xy_hit    = (state == DRAIN) & xy_ready_i & (bin_num_i == last_bin) & ~sym_done_o;
  assign stop_now  = stop_latched | stop_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rd_active       <= 1'b0;
      stop_latched    <= 1'b0;
      total_bits      <= '0;
      last_bin        <= '0;
      bytes_left      <= '0;
      tbl_addr_o      <= '0;
      enc_we_conf_o   <= 1'b0;
      enc_addr_o      <= '0;
      cfg_done_o      <= 1'b0;
      cfg_err_o       <= 1'b0;
      sym_done_o      <= 1'b0;
      sym_cnt_o       <= '0;
      underrun_o      <= 1'b0;
      bytes_per_sym_o <= '0;
    end else begin
      cfg_done_o    <= 1'b0;
      sym_done_o    <= 1'b0;
      enc_we_conf_o <= 1'b0;
      if (state != IDLE && stop_i) stop_latched <= 1'b1;

      case (state)
        IDLE: begin
          if (start_i) begin
            state        <= CFG;
            rd_active    <= 1'b1;
            tbl_addr_o   <= '0;
            cfg_err_o    <= 1'b0;
            underrun_o   <= 1'b0;
            sym_cnt_o    <= '0;
            total_bits   <= '0;
            last_bin     <= '0;
            stop_latched <= 1'b0;
          end
        end

        CFG: begin
          enc_we_conf_o <= rd_active;
          enc_addr_o    <= tbl_addr_o;
          if (rd_active) begin
            if (tbl_addr_o == LAST_ADDR) rd_active <= 1'b0;
            else tbl_addr_o <= tbl_addr_o + 1'b1;
          end
          if (enc_we_conf_o) begin
            total_bits <= total_bits + 12'(tbl_data_i);
            if (tbl_data_i != 4'd0) last_bin <= enc_addr_o;
            if (enc_addr_o == LAST_ADDR) begin
              cfg_done_o      <= 1'b1;
              bytes_per_sym_o <= total_sum[11:3];
            end
          end
          if (cfg_done_o) begin
            bytes_left <= bytes_per_sym_o;
            if (total_bits == 12'd0) begin
              cfg_err_o <= 1'b1;
              state     <= IDLE;
            end else if (stop_now) begin
              state <= IDLE;
            end else begin
              state <= FEED;
            end
          end
        end

        FEED: begin
          if (enc_input_ready_i) begin
            if (fifo_empty_i) begin
              underrun_o <= 1'b1;
            end else begin
              bytes_left <= bytes_left - 9'd1;
              if (bytes_left == 9'd1) state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (xy_hit) begin
            sym_done_o <= 1'b1;
            sym_cnt_o  <= sym_cnt_o + 1'b1;
          end
          // Symbol boundary: the cycle carrying sym_done decides between next symbol and stop.
          if (sym_done_o) begin
            bytes_left <= bytes_per_sym_o;
            state      <= stop_now ? IDLE : FEED;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
